// File: rtl/scan_sequencer.sv
// UART-byte driven scan sequencer: header parser selects a tap,
// data bytes are shifted LSB first on tck/tdi/tms and tdo is returned.
module scan_sequencer #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter logic [7:0] DESELECT_BYTE = 8'h5A,
  parameter int         ADDR_WIDTH    = 16,
  parameter int         TCK_DIV       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  mode,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tck,
  output logic                  tdi,
  input  logic                  tdo,
  output logic                  tms,
  output logic                  tap_sel,
  output logic [ADDR_WIDTH-1:0] tap_addr,
  output logic                  busy,
  output logic                  err
);

  localparam int DW = $clog2(TCK_DIV + 1);
  localparam logic [DW-1:0] LAST = DW'(TCK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  typedef enum logic [1:0] {P_SYNC, P_HI, P_LO} pstate_t;

  state_t                state_q, state_d;
  pstate_t               pst_q, pst_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  sel_d;
  logic [6:0]            sreg_q, sreg_d;
  logic [7:0]            cap_q, cap_d;
  logic [7:0]            txd_d;
  logic                  txv_d;
  logic                  tck_d, tdi_d, err_d;
  logic [DW-1:0]         div_q, div_d;
  logic [2:0]            bit_q, bit_d;
  logic                  addr_byte, data_byte;

  assign addr_byte = rx_valid & ~mode;
  assign data_byte = rx_valid & mode;
  assign tms  = (state_q == SHIFT);
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pst_d   = pst_q;
    hi_d    = hi_q;
    addr_d  = tap_addr;
    sel_d   = tap_sel;
    sreg_d  = sreg_q;
    cap_d   = cap_q;
    txd_d   = tx_data;
    txv_d   = tx_valid;
    tck_d   = tck;
    tdi_d   = tdi;
    div_d   = div_q;
    bit_d   = bit_q;
    err_d   = data_byte & ((state_q != IDLE) | ~tap_sel);

    // header parser runs independently of any shift in flight
    if (addr_byte) begin
      unique case (1'b1)
        pst_q == P_SYNC: begin
          if (rx_data == SYNC_BYTE)
            pst_d = P_HI;
          else if (rx_data == DESELECT_BYTE)
            sel_d = 1'b0;
        end
        pst_q == P_HI: begin
          hi_d  = rx_data;
          pst_d = P_LO;
        end
        pst_q == P_LO: begin
          addr_d = ADDR_WIDTH'({hi_q, rx_data});
          sel_d  = 1'b1;
          pst_d  = P_SYNC;
        end
        default: pst_d = P_SYNC;
      endcase
    end else if (data_byte) begin
      pst_d = P_SYNC;
    end

    unique case (1'b1)
      state_q == IDLE: begin
        if (data_byte && tap_sel) begin
          state_d = SHIFT;
          sreg_d  = rx_data[7:1];
          tdi_d   = rx_data[0];
          tck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      state_q == SHIFT: begin
        if (div_q == LAST) begin
          div_d = '0;
          tck_d = ~tck;
          // falling tck edge: capture tdo, present next tdi
          if (tck) begin
            cap_d  = {tdo, cap_q[7:1]};
            tdi_d  = sreg_q[0];
            sreg_d = {1'b0, sreg_q[6:1]};
            bit_d  = 3'(bit_q + 3'd1);
            if (bit_q == 3'd7) begin
              state_d = RESP;
              tck_d   = 1'b0;
              tdi_d   = 1'b0;
              txd_d   = {tdo, cap_q[7:1]};
              txv_d   = 1'b1;
            end
          end
        end else begin
          div_d = DW'(div_q + 1'b1);
        end
      end
      state_q == RESP: begin
        if (tx_ready) begin
          txv_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pst_q    <= P_SYNC;
      hi_q     <= '0;
      tap_addr <= '0;
      tap_sel  <= 1'b0;
      sreg_q   <= '0;
      cap_q    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tck      <= 1'b0;
      tdi      <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pst_q    <= pst_d;
      hi_q     <= hi_d;
      tap_addr <= addr_d;
      tap_sel  <= sel_d;
      sreg_q   <= sreg_d;
      cap_q    <= cap_d;
      tx_data  <= txd_d;
      tx_valid <= txv_d;
      tck      <= tck_d;
      tdi      <= tdi_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: header parse, loopback and
// inverted shifts, overrun, deselect, aborted header, reset mid-shift.
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tck, tdi, tdo, tms;
  logic        tap_sel;
  logic [15:0] tap_addr;
  logic        busy, err;
  logic        inv = 1'b0;

  int errors = 0;
  int checks = 0;

  int         rises = 0;
  int         err_cnt = 0;
  int         txv_cnt = 0;
  logic [7:0] tdi_log = '0;
  logic       tms_bad = 1'b0;
  logic       tck_q = 1'b0;

  assign tdo = inv ? ~tdi : tdi;

  always #5 clk = ~clk;

  scan_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .mode     (mode),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tck      (tck),
    .tdi      (tdi),
    .tdo      (tdo),
    .tms      (tms),
    .tap_sel  (tap_sel),
    .tap_addr (tap_addr),
    .busy     (busy),
    .err      (err)
  );

  always @(negedge clk) begin
    if (tck && !tck_q) begin
      rises++;
      tdi_log = {tdi, tdi_log[7:1]};
      if (!tms) tms_bad = 1'b1;
    end
    tck_q = tck;
    if (err) err_cnt++;
    if (tx_valid) txv_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic m, input logic [7:0] b);
    @(posedge clk) #1;
    rx_valid = 1'b1;
    mode     = m;
    rx_data  = b;
    @(posedge clk) #1;
    rx_valid = 1'b0;
    mode     = 1'b0;
    rx_data  = '0;
  endtask

  task automatic clr();
    rises   = 0;
    err_cnt = 0;
    txv_cnt = 0;
    tdi_log = '0;
    tms_bad = 1'b0;
  endtask

  task automatic handshake();
    @(posedge clk) #1;
    tx_ready = 1'b1;
    @(posedge clk) #1;
    tx_ready = 1'b0;
  endtask

  initial begin
    logic got_resp;

    // 1: reset with random input activity
    repeat (6) begin
      @(posedge clk) #1;
      rx_valid = 1'($urandom);
      mode     = 1'($urandom);
      rx_data  = 8'($urandom);
      tx_ready = 1'($urandom);
    end
    check("rst_tck", tck, 0);
    check("rst_tms", tms, 0);
    check("rst_tdi", tdi, 0);
    check("rst_txv", tx_valid, 0);
    check("rst_sel", tap_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_addr", tap_addr, 16'h0000);
    rx_valid = 1'b0;
    mode     = 1'b0;
    rx_data  = '0;
    tx_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_tms", tms, 0);

    // 2: address select
    clr();
    send(1'b0, 8'hA5);
    send(1'b0, 8'h00);
    send(1'b0, 8'h02);
    check("sel_on", tap_sel, 1);
    check("sel_addr", tap_addr, 16'h0002);
    check("sel_no_tck", rises, 0);

    // 3: loopback shift of 7F
    clr();
    send(1'b1, 8'h7F);
    check("sh_tms", tms, 1);
    check("sh_busy", busy, 1);
    check("sh_tck0", tck, 0);
    check("sh_tdi0", tdi, 1);
    repeat (63) @(posedge clk);
    #1;
    check("sh_txv_early", tx_valid, 0);
    @(posedge clk) #1;
    check("sh_txv", tx_valid, 1);
    check("sh_txd", tx_data, 8'h7F);
    check("sh_tms_end", tms, 0);
    check("sh_rises", rises, 8);
    check("sh_tdi_seq", tdi_log, 8'h7F);
    check("sh_tms_win", tms_bad, 0);
    repeat (10) @(posedge clk);
    #1;
    check("hold_txv", tx_valid, 1);
    check("hold_txd", tx_data, 8'h7F);
    check("hold_busy", busy, 1);
    handshake();
    check("hs_txv", tx_valid, 0);
    check("hs_busy", busy, 0);

    // 4: inverted tdo with an overrun byte
    clr();
    inv = 1'b1;
    send(1'b1, 8'h08);
    repeat (9) @(posedge clk);
    send(1'b1, 8'hFF);
    check("ovr_err", err, 1);
    got_resp = 1'b0;
    for (int i = 0; i < 100 && !got_resp; i++) begin
      @(posedge clk) #1;
      if (tx_valid) got_resp = 1'b1;
    end
    check("ovr_resp_seen", got_resp, 1);
    check("ovr_txd", tx_data, 8'hF7);
    check("ovr_rises", rises, 8);
    check("ovr_err_cnt", err_cnt, 1);
    handshake();
    repeat (80) @(posedge clk);
    #1;
    check("ovr_no_2nd", rises, 8);
    check("ovr_idle_txv", tx_valid, 0);
    inv = 1'b0;

    // 5: deselect, then a data byte with no tap
    send(1'b0, 8'h5A);
    check("desel", tap_sel, 0);
    clr();
    send(1'b1, 8'hA5);
    check("notap_err", err, 1);
    repeat (20) @(posedge clk);
    #1;
    check("notap_rises", rises, 0);
    check("notap_txv", txv_cnt, 0);
    check("notap_errs", err_cnt, 1);

    // 6a: header aborted by a data byte
    send(1'b0, 8'hA5);
    send(1'b0, 8'h01);
    send(1'b1, 8'h33);
    check("abort_addr", tap_addr, 16'h0002);
    check("abort_sel", tap_sel, 0);
    send(1'b0, 8'h03);
    check("abort_sync", tap_addr, 16'h0002);
    send(1'b0, 8'hA5);
    send(1'b0, 8'h00);
    send(1'b0, 8'h07);
    check("resel_addr", tap_addr, 16'h0007);
    check("resel_on", tap_sel, 1);

    // 6b: reset during bit 3
    clr();
    send(1'b1, 8'hC3);
    repeat (26) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rises", rises, 3);
    check("mid_tck", tck, 0);
    check("mid_tms", tms, 0);
    check("mid_tdi", tdi, 0);
    check("mid_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("mid_no_resp", txv_cnt, 0);
    check("mid_no_tck", rises, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
